// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the MEM stage and the
// data-memory responder.
interface dmem_responder_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              misalign_err;
  logic              mem_stall;

  // Pipeline side: issues requests, consumes responses and the stall.
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, misalign_err, mem_stall
  );

  // Responder side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, misalign_err, mem_stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. Accepts one load or
// store in IDLE, waits LATENCY cycles while stalling the pipeline, then
// presents a one-cycle registered response. Misaligned word accesses skip
// the array and respond after a single stall cycle with misalign_err set.
module dmem_responder #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 2048,
  parameter int LATENCY     = 2
) (
  input  logic           CLK,
  input  logic           RST,
  dmem_responder_if.slave bus
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam int          WADDR_W  = ADDR_W - 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           count;

  // Request latched at accept time.
  logic                 wr_p0;
  logic                 mis_p0;
  logic [WADDR_W-1:0]   waddr_p0;
  logic [DATA_W-1:0]    wdata_p0;

  // Registered response.
  logic                 vld_p1;
  logic                 mis_p1;
  logic [DATA_W-1:0]    rdata_p1;

  logic [DATA_W-1:0]    mem [DEPTH_WORDS];

  // Request seen this cycle: live inputs while IDLE, latched copy afterwards.
  logic                 cur_wr;
  logic                 cur_mis;
  logic [WADDR_W-1:0]   cur_waddr;
  logic [DATA_W-1:0]    cur_wdata;
  logic [IDX_W-1:0]     cur_idx;
  logic                 accept;
  logic                 enter_resp;
  logic                 do_access;

  // Word index wraps modulo the array depth.
  function automatic logic [IDX_W-1:0] idx_of(input logic [WADDR_W-1:0] waddr);
    return IDX_W'(32'(waddr) % DEPTH_WORDS);
  endfunction

  // Select the active request and decide whether this edge enters RESP.
  always_comb begin
    accept     = 1'b0;
    cur_wr     = wr_p0;
    cur_mis    = mis_p0;
    cur_waddr  = waddr_p0;
    cur_wdata  = wdata_p0;
    enter_resp = 1'b0;
    if (state == S_IDLE) begin
      accept    = bus.req_valid;
      cur_wr    = bus.req_write;
      cur_mis   = |bus.req_addr[1:0];
      cur_waddr = bus.req_addr[ADDR_W-1:2];
      cur_wdata = bus.req_wdata;
      enter_resp = accept && ((LATENCY == 1) || cur_mis);
    end else if (state == S_WAIT) begin
      enter_resp = (count == 4'd0);
    end
    cur_idx   = idx_of(cur_waddr);
    do_access = enter_resp && !cur_mis && !RST;
  end

  // Handshake and stall outputs; both are forced low while reset is held.
  assign bus.req_ready    = (state == S_IDLE) && !RST;
  assign bus.mem_stall    = !RST && (((state == S_IDLE) && bus.req_valid) || (state == S_WAIT));
  assign bus.resp_valid   = vld_p1;
  assign bus.resp_rdata   = rdata_p1;
  assign bus.misalign_err = mis_p1;

  // Array write: stores commit only on the edge entering RESP, never under reset.
  always_ff @(posedge CLK) begin
    if (do_access && cur_wr) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  // Control FSM, request latch and registered response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      count    <= 4'd0;
      wr_p0    <= 1'b0;
      mis_p0   <= 1'b0;
      waddr_p0 <= '0;
      wdata_p0 <= '0;
      vld_p1   <= 1'b0;
      mis_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= enter_resp;
      mis_p1   <= enter_resp && cur_mis;
      rdata_p1 <= (do_access && !cur_wr) ? mem[cur_idx] : '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_p0    <= cur_wr;
            mis_p0   <= cur_mis;
            waddr_p0 <= cur_waddr;
            wdata_p0 <= cur_wdata;
            if ((LATENCY == 1) || cur_mis) begin
              state <= S_RESP;
            end else begin
              count <= CNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (count == 4'd0) begin
            state <= S_RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2 and one at
// LATENCY=1, driven right after the rising edge and sampled on the falling edge.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   pulses;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(13), .DATA_W(32)) ifa ();
  dmem_responder_if #(.ADDR_W(13), .DATA_W(32)) ifb ();

  dmem_responder #(.ADDR_W(13), .DATA_W(32), .DEPTH_WORDS(2048), .LATENCY(2)) dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (ifa.slave)
  );

  dmem_responder #(.ADDR_W(13), .DATA_W(32), .DEPTH_WORDS(2048), .LATENCY(1)) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (ifb.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive_a(input logic v, input logic w, input logic [12:0] a, input logic [31:0] d);
    ifa.req_valid = v; ifa.req_write = w; ifa.req_addr = a; ifa.req_wdata = d;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic [12:0] a, input logic [31:0] d);
    ifb.req_valid = v; ifb.req_write = w; ifb.req_addr = a; ifb.req_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [13:0] wide_addr;

  initial begin
    rst = 1'b1;
    drive_a(1'b1, 1'b0, 13'h0, 32'h0);
    drive_b(1'b0, 1'b0, 13'h0, 32'h0);
    tick(); tick();
    sample();
    check_val("rst_ready",  32'(ifa.req_ready), 32'd0);
    check_val("rst_stall",  32'(ifa.mem_stall), 32'd0);
    check_val("rst_rvalid", 32'(ifa.resp_valid), 32'd0);
    check_val("rst_rdata",  ifa.resp_rdata, 32'd0);
    check_val("rst_mis",    32'(ifa.misalign_err), 32'd0);

    // 1: store 0xDEADBEEF to 0x0040
    tick(); rst = 1'b0; drive_a(1'b1, 1'b1, 13'h0040, 32'hDEADBEEF);
    sample();
    check_val("t1_ready_T",  32'(ifa.req_ready), 32'd1);
    check_val("t1_stall_T",  32'(ifa.mem_stall), 32'd1);
    tick(); sample();
    check_val("t1_stall_T1", 32'(ifa.mem_stall), 32'd1);
    check_val("t1_ready_T1", 32'(ifa.req_ready), 32'd0);
    check_val("t1_rv_T1",    32'(ifa.resp_valid), 32'd0);
    tick(); sample();
    check_val("t1_rv_T2",    32'(ifa.resp_valid), 32'd1);
    check_val("t1_rdata",    ifa.resp_rdata, 32'd0);
    check_val("t1_stall_T2", 32'(ifa.mem_stall), 32'd0);
    check_val("t1_ready_T2", 32'(ifa.req_ready), 32'd0);

    // 2: load 0x0040 back
    tick(); drive_a(1'b1, 1'b0, 13'h0040, 32'h0);
    sample();
    check_val("t2_ready", 32'(ifa.req_ready), 32'd1);
    check_val("t2_rv_T3", 32'(ifa.resp_valid), 32'd0);
    tick(); sample();
    check_val("t2_rv_T4", 32'(ifa.resp_valid), 32'd0);
    tick(); sample();
    check_val("t2_rv",    32'(ifa.resp_valid), 32'd1);
    check_val("t2_rdata", ifa.resp_rdata, 32'hDEADBEEF);
    check_val("t2_mis",   32'(ifa.misalign_err), 32'd0);
    check_val("t2_stall", 32'(ifa.mem_stall), 32'd0);

    // 3: misaligned store to 0x0042
    tick(); drive_a(1'b1, 1'b1, 13'h0042, 32'h12345678);
    sample();
    check_val("t3_stall", 32'(ifa.mem_stall), 32'd1);
    tick(); sample();
    check_val("t3_rv",    32'(ifa.resp_valid), 32'd1);
    check_val("t3_mis",   32'(ifa.misalign_err), 32'd1);
    check_val("t3_rdata", ifa.resp_rdata, 32'd0);
    check_val("t3_stall_resp", 32'(ifa.mem_stall), 32'd0);
    tick(); drive_a(1'b1, 1'b0, 13'h0040, 32'h0);
    sample();
    check_val("t3_mis_clr", 32'(ifa.misalign_err), 32'd0);
    check_val("t3_rv_clr",  32'(ifa.resp_valid), 32'd0);
    tick(); tick(); sample();
    check_val("t3_mem_kept", ifa.resp_rdata, 32'hDEADBEEF);

    // 4: reset during WAIT of a load, then of a store
    tick(); drive_a(1'b1, 1'b0, 13'h0040, 32'h0);
    tick(); rst = 1'b1;
    sample();
    check_val("t4_stall_rst", 32'(ifa.mem_stall), 32'd0);
    check_val("t4_ready_rst", 32'(ifa.req_ready), 32'd0);
    tick(); rst = 1'b0; drive_a(1'b0, 1'b0, 13'h0, 32'h0);
    sample();
    check_val("t4_rv",    32'(ifa.resp_valid), 32'd0);
    check_val("t4_rdata", ifa.resp_rdata, 32'd0);
    check_val("t4_idle",  32'(ifa.req_ready), 32'd1);
    check_val("t4_stall_idle", 32'(ifa.mem_stall), 32'd0);
    tick(); drive_a(1'b1, 1'b1, 13'h0040, 32'h11111111);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; drive_a(1'b0, 1'b0, 13'h0, 32'h0);
    sample();
    check_val("t4_rv_st", 32'(ifa.resp_valid), 32'd0);
    tick(); drive_a(1'b1, 1'b0, 13'h0040, 32'h0);
    tick(); tick(); sample();
    check_val("t4_rv_ld",      32'(ifa.resp_valid), 32'd1);
    check_val("t4_store_drop", ifa.resp_rdata, 32'hDEADBEEF);

    // 5: req_valid held high: store then load at the top word (both index 2047)
    pulses = 0;
    tick(); drive_a(1'b1, 1'b1, 13'h1FFC, 32'hCAFEF00D);
    sample(); pulses += int'(ifa.resp_valid);
    tick(); sample(); pulses += int'(ifa.resp_valid);
    tick(); sample(); pulses += int'(ifa.resp_valid);
    check_val("t5_st_rv", 32'(ifa.resp_valid), 32'd1);
    wide_addr = 14'h3FFC;
    tick(); drive_a(1'b1, 1'b0, wide_addr[12:0], 32'h0);
    sample(); pulses += int'(ifa.resp_valid);
    check_val("t5_no_reaccept", 32'(ifa.req_ready), 32'd1);
    tick(); sample(); pulses += int'(ifa.resp_valid);
    tick(); sample(); pulses += int'(ifa.resp_valid);
    check_val("t5_ld_rdata", ifa.resp_rdata, 32'hCAFEF00D);
    tick(); drive_a(1'b0, 1'b0, 13'h0, 32'h0);
    sample(); pulses += int'(ifa.resp_valid);
    check_val("t5_pulses", 32'(pulses), 32'd2);

    // 6: LATENCY=1 instance
    tick(); drive_b(1'b1, 1'b1, 13'h0000, 32'h000000AA);
    sample();
    check_val("t6_st_stall", 32'(ifb.mem_stall), 32'd1);
    tick(); sample();
    check_val("t6_st_rv",    32'(ifb.resp_valid), 32'd1);
    check_val("t6_st_rdata", ifb.resp_rdata, 32'd0);
    check_val("t6_st_stall_resp", 32'(ifb.mem_stall), 32'd0);
    tick(); drive_b(1'b1, 1'b0, 13'h0000, 32'h0);
    sample();
    check_val("t6_ld_stall", 32'(ifb.mem_stall), 32'd1);
    tick(); sample();
    check_val("t6_ld_rv",    32'(ifb.resp_valid), 32'd1);
    check_val("t6_ld_rdata", ifb.resp_rdata, 32'h000000AA);
    tick(); drive_b(1'b0, 1'b0, 13'h0, 32'h0);
    sample();
    check_val("t6_rv_clr", 32'(ifb.resp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
